// File: rtl/gem_rx_seq_pkg.sv
// gem_rx_seq_pkg
//   Shared types for the GEM RX frame sequencer.
//   - state_t : per-frame sequencing state (IDLE / FRAME / DROP)
//   - desc_t  : descriptor pushed per good frame {start, len, status}
//   The descriptor address fields are sized for the largest supported
//   buffer (MAX_ADDR_W). Users zero-extend into them and slice back out.
`timescale 1ns/1ps
package gem_rx_seq_pkg;

    localparam int STATUS_W   = 45;
    // Largest ADDR_W the sequencer may be built with.
    localparam int MAX_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DROP
    } state_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] start;
        logic [MAX_ADDR_W:0]   len;
        logic [STATUS_W-1:0]   status;
    } desc_t;

endpackage

// File: rtl/gem_rx_desc_fifo.sv
// gem_rx_desc_fifo
//   First-word-fall-through descriptor FIFO, DEPTH entries of desc_t.
//   The head entry is presented on rd_desc whenever empty is low.
//   A push into a full FIFO is accepted when a pop happens in the
//   same cycle, because the pop frees the slot first.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write wr_desc (dropped if full and no pop)
//   pop        : retire the head entry (ignored when empty)
//   wr_desc    : entry to write
//   rd_desc    : head entry
//   full/empty : occupancy flags
`timescale 1ns/1ps
module gem_rx_desc_fifo
    import gem_rx_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  desc_t wr_desc,
    output desc_t rd_desc,
    output logic  full,
    output logic  empty
);

    localparam int PW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty.
    logic [PW:0] wp;
    logic [PW:0] rp;
    desc_t       mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wp == rp);
    assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_desc = mem[rp[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wp[PW-1:0]] <= wr_desc;
                wp              <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gem_rx_frame_sequencer.sv
// gem_rx_frame_sequencer
//   Sequences the GEM RX FIFO-write stream into a circular word buffer
//   and issues one descriptor per good frame. Partial, errored and
//   overflowed frames are rolled back to the last committed pointer.
// Ports
//   rx_clock, rx_reset        : clock, asynchronous active-high reset
//   rx_w_wr/data/sop/eop      : GEM word stream
//   rx_w_status               : frame status, valid with eop
//   rx_w_err                  : frame error on any qualified word
//   rx_w_flush                : drop the frame in progress
//   rx_w_overflow             : buffer/descriptor overflow back to GEM
//   buf_wr_en/addr/data       : registered buffer write port
//   buf_rd_ptr                : consumer read pointer (wrap bit in MSB)
//   desc_valid/ready          : descriptor handshake
//   desc_start/len/status     : head descriptor
// Configuration
//   GEM_RX_SEQ_STATS_EN : adds stat_clear, stat_frames, stat_drops
//                         saturating frame/drop counters.
`timescale 1ns/1ps
module gem_rx_frame_sequencer
    import gem_rx_seq_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DESC_DEPTH = 4
) (
    input  logic                rx_clock,
    input  logic                rx_reset,
    input  logic                rx_w_wr,
    input  logic [31:0]         rx_w_data,
    input  logic                rx_w_sop,
    input  logic                rx_w_eop,
    input  logic [STATUS_W-1:0] rx_w_status,
    input  logic                rx_w_err,
    input  logic                rx_w_flush,
    output logic                rx_w_overflow,
    output logic                buf_wr_en,
    output logic [ADDR_W-1:0]   buf_wr_addr,
    output logic [31:0]         buf_wr_data,
    input  logic [ADDR_W:0]     buf_rd_ptr,
    output logic                desc_valid,
    input  logic                desc_ready,
    output logic [ADDR_W-1:0]   desc_start,
    output logic [ADDR_W:0]     desc_len,
    output logic [STATUS_W-1:0] desc_status
`ifdef GEM_RX_SEQ_STATS_EN
    ,
    input  logic                stat_clear,
    output logic [31:0]         stat_frames,
    output logic [31:0]         stat_drops
`endif
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state, state_d;
    logic [ADDR_W:0] wr_ptr, wr_ptr_d;
    logic [ADDR_W:0] cmt_ptr, cmt_ptr_d;
    logic            err_seen, err_d;

    logic [ADDR_W:0] base;       // address this word would be written to
    logic [ADDR_W:0] next_ptr;
    logic [ADDR_W:0] used;
    logic            full;
    logic            err_frame;
    logic            do_write;
    logic            push;
    logic            pulse;      // one-cycle overflow for frames lost at eop
    logic [1:0]      drop_inc;   // frames discarded this cycle

    desc_t           push_desc;
    desc_t           head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            can_push;
    logic [ADDR_W:0] frame_len;

    // A sop always restarts at the committed pointer, which also discards
    // any partial frame still open.
    assign base      = rx_w_sop ? cmt_ptr : wr_ptr;
    assign next_ptr  = base + ONE;
    // Full is measured against the consumer, so committed-but-unread
    // words are never overwritten.
    assign used      = base - buf_rd_ptr;
    assign full      = (used == CAP);
    assign err_frame = (rx_w_sop ? 1'b0 : err_seen) | rx_w_err;
    assign pop       = desc_valid && desc_ready;
    assign can_push  = !fifo_full || pop;
    assign frame_len = next_ptr - cmt_ptr;

    always_comb begin
        state_d   = state;
        wr_ptr_d  = wr_ptr;
        cmt_ptr_d = cmt_ptr;
        err_d     = err_seen;
        do_write  = 1'b0;
        push      = 1'b0;
        pulse     = 1'b0;
        drop_inc  = 2'd0;
        if (rx_w_flush) begin
            wr_ptr_d = cmt_ptr;
            state_d  = IDLE;
            err_d    = 1'b0;
            if (state == FRAME) drop_inc = 2'd1;
        end else if (rx_w_wr) begin
            if (rx_w_sop || state == FRAME) begin
                if (rx_w_sop && state == FRAME) drop_inc = 2'd1;
                if (full) begin
                    wr_ptr_d = cmt_ptr;
                    err_d    = 1'b0;
                    drop_inc = drop_inc + 2'd1;
                    if (rx_w_eop) begin
                        state_d = IDLE;
                        pulse   = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end else begin
                    do_write = 1'b1;
                    wr_ptr_d = next_ptr;
                    if (rx_w_eop) begin
                        state_d = IDLE;
                        err_d   = 1'b0;
                        if (!err_frame && can_push) begin
                            push      = 1'b1;
                            cmt_ptr_d = next_ptr;
                        end else begin
                            wr_ptr_d = cmt_ptr;
                            drop_inc = drop_inc + 2'd1;
                            pulse    = !err_frame;
                        end
                    end else begin
                        state_d = FRAME;
                        err_d   = err_frame;
                    end
                end
            end else if (state == DROP && rx_w_eop) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge rx_clock or posedge rx_reset) begin
        if (rx_reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            cmt_ptr       <= '0;
            err_seen      <= 1'b0;
            rx_w_overflow <= 1'b0;
            buf_wr_en     <= 1'b0;
            buf_wr_addr   <= '0;
            buf_wr_data   <= '0;
        end else begin
            state         <= state_d;
            wr_ptr        <= wr_ptr_d;
            cmt_ptr       <= cmt_ptr_d;
            err_seen      <= err_d;
            // Held while dropping, single pulse for eop-time losses.
            rx_w_overflow <= (state_d == DROP) || pulse;
            buf_wr_en     <= do_write;
            buf_wr_addr   <= base[ADDR_W-1:0];
            buf_wr_data   <= rx_w_data;
        end
    end

    always_comb begin
        push_desc        = '0;
        push_desc.start  = MAX_ADDR_W'(cmt_ptr[ADDR_W-1:0]);
        push_desc.len    = (MAX_ADDR_W+1)'(frame_len);
        push_desc.status = rx_w_status;
    end

    gem_rx_desc_fifo #(
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk     (rx_clock),
        .rst     (rx_reset),
        .push    (push),
        .pop     (pop),
        .wr_desc (push_desc),
        .rd_desc (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign desc_valid  = !fifo_empty;
    assign desc_start  = head.start[ADDR_W-1:0];
    assign desc_len    = head.len[ADDR_W:0];
    assign desc_status = head.status;

    // Upper descriptor bits are always zero for ADDR_W < MAX_ADDR_W.
    logic unused_desc_hi;
    assign unused_desc_hi = ^{head.start, head.len};

`ifdef GEM_RX_SEQ_STATS_EN
    logic [32:0] drops_sum;
    assign drops_sum = {1'b0, stat_drops} + {31'd0, drop_inc};

    always_ff @(posedge rx_clock or posedge rx_reset) begin
        if (rx_reset) begin
            stat_frames <= '0;
            stat_drops  <= '0;
        end else if (stat_clear) begin
            stat_frames <= '0;
            stat_drops  <= '0;
        end else begin
            if (push && stat_frames != 32'hFFFF_FFFF) begin
                stat_frames <= stat_frames + 32'd1;
            end
            stat_drops <= drops_sum[32] ? 32'hFFFF_FFFF : drops_sum[31:0];
        end
    end
`else
    logic unused_drop_inc;
    assign unused_drop_inc = ^drop_inc;
`endif

endmodule

// File: tb/tb_gem_rx_frame_sequencer.sv
`timescale 1ns/1ps
module tb_gem_rx_frame_sequencer;
    import gem_rx_seq_pkg::*;

    localparam int AW = 4;
    localparam int DD = 2;

    logic                rx_clock = 1'b0;
    logic                rx_reset;
    logic                rx_w_wr, rx_w_sop, rx_w_eop, rx_w_err, rx_w_flush;
    logic [31:0]         rx_w_data;
    logic [STATUS_W-1:0] rx_w_status;
    logic                rx_w_overflow;
    logic                buf_wr_en;
    logic [AW-1:0]       buf_wr_addr;
    logic [31:0]         buf_wr_data;
    logic [AW:0]         buf_rd_ptr;
    logic                desc_valid, desc_ready;
    logic [AW-1:0]       desc_start;
    logic [AW:0]         desc_len;
    logic [STATUS_W-1:0] desc_status;

    int pass_cnt = 0;
    int total    = 0;

    gem_rx_frame_sequencer #(.ADDR_W(AW), .DESC_DEPTH(DD)) dut (
        .rx_clock      (rx_clock),
        .rx_reset      (rx_reset),
        .rx_w_wr       (rx_w_wr),
        .rx_w_data     (rx_w_data),
        .rx_w_sop      (rx_w_sop),
        .rx_w_eop      (rx_w_eop),
        .rx_w_status   (rx_w_status),
        .rx_w_err      (rx_w_err),
        .rx_w_flush    (rx_w_flush),
        .rx_w_overflow (rx_w_overflow),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_addr   (buf_wr_addr),
        .buf_wr_data   (buf_wr_data),
        .buf_rd_ptr    (buf_rd_ptr),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_start    (desc_start),
        .desc_len      (desc_len),
        .desc_status   (desc_status)
    );

    always #5 rx_clock = ~rx_clock;

    task automatic apply_reset();
        rx_reset = 1'b1;
        rx_w_wr = 0; rx_w_sop = 0; rx_w_eop = 0; rx_w_err = 0; rx_w_flush = 0;
        rx_w_data = '0; rx_w_status = '0; buf_rd_ptr = '0; desc_ready = 0;
        @(posedge rx_clock); @(posedge rx_clock); #1;
        rx_reset = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                             input logic err, input logic [STATUS_W-1:0] st);
        rx_w_wr = 1; rx_w_data = d; rx_w_sop = sop; rx_w_eop = eop;
        rx_w_err = err; rx_w_status = st;
        @(posedge rx_clock); #1;
        rx_w_wr = 0; rx_w_sop = 0; rx_w_eop = 0; rx_w_err = 0;
    endtask

    task automatic pop_desc();
        desc_ready = 1;
        @(posedge rx_clock); #1;
        desc_ready = 0;
    endtask

    task automatic test_reset();
        rx_reset = 1'b1;
        rx_w_wr = 0; rx_w_sop = 0; rx_w_eop = 0; rx_w_err = 0; rx_w_flush = 0;
        rx_w_data = '0; rx_w_status = '0; buf_rd_ptr = '0; desc_ready = 0;
        #12;
        total++;
        if ({rx_w_overflow, buf_wr_en, desc_valid} !== 3'b000)
            $display("FAIL reset_flags: got ovf=%b wr_en=%b valid=%b want 0 0 0",
                     rx_w_overflow, buf_wr_en, desc_valid);
        else pass_cnt++;
        total++;
        if (buf_wr_addr !== '0 || buf_wr_data !== '0)
            $display("FAIL reset_buf: got addr=%0d data=%h want 0 0", buf_wr_addr, buf_wr_data);
        else pass_cnt++;
        total++;
        if (desc_start !== '0 || desc_len !== '0 || desc_status !== '0)
            $display("FAIL reset_desc: got start=%0d len=%0d status=%h want 0 0 0",
                     desc_start, desc_len, desc_status);
        else pass_cnt++;
        @(posedge rx_clock); #1;
        rx_reset = 1'b0;
    endtask

    task automatic test_four_word();
        logic [31:0] d;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            d = 32'hA0 + 32'(i);
            send_word(d, i == 0, i == 3, 1'b0, 45'h1_2345_6789);
            total++;
            if (buf_wr_en !== 1'b1 || buf_wr_addr !== AW'(i) || buf_wr_data !== d)
                $display("FAIL four_word_wr%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                         i, buf_wr_en, buf_wr_addr, buf_wr_data, i, d);
            else pass_cnt++;
        end
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd0 || desc_len !== 5'd4 || desc_status !== 45'h1_2345_6789)
            $display("FAIL four_word_desc: got v=%b start=%0d len=%0d st=%h want 1 0 4 123456789",
                     desc_valid, desc_start, desc_len, desc_status);
        else pass_cnt++;
        pop_desc();
        total++;
        if (desc_valid !== 1'b0)
            $display("FAIL four_word_pop: got valid=%b want 0", desc_valid);
        else pass_cnt++;
    endtask

    task automatic test_single_word();
        apply_reset();
        send_word(32'hB0, 1'b1, 1'b1, 1'b0, 45'h55);
        send_word(32'hB1, 1'b1, 1'b0, 1'b0, 45'h0);
        total++;
        if (buf_wr_addr !== 4'd1)
            $display("FAIL single_next_addr: got %0d want 1", buf_wr_addr);
        else pass_cnt++;
        send_word(32'hB2, 1'b0, 1'b1, 1'b0, 45'h66);
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd0 || desc_len !== 5'd1 || desc_status !== 45'h55)
            $display("FAIL single_desc: got v=%b start=%0d len=%0d st=%h want 1 0 1 55",
                     desc_valid, desc_start, desc_len, desc_status);
        else pass_cnt++;
        pop_desc();
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd1 || desc_len !== 5'd2 || desc_status !== 45'h66)
            $display("FAIL single_next_desc: got v=%b start=%0d len=%0d st=%h want 1 1 2 66",
                     desc_valid, desc_start, desc_len, desc_status);
        else pass_cnt++;
        pop_desc();
    endtask

    // Continues from test_single_word: committed pointer is 3.
    task automatic test_err_frame();
        for (int i = 0; i < 4; i++)
            send_word(32'hC0 + 32'(i), i == 0, i == 3, i == 2, 45'h77);
        @(posedge rx_clock); #1;
        total++;
        if (desc_valid !== 1'b0 || rx_w_overflow !== 1'b0)
            $display("FAIL err_no_desc: got valid=%b ovf=%b want 0 0", desc_valid, rx_w_overflow);
        else pass_cnt++;
        send_word(32'hC9, 1'b1, 1'b1, 1'b0, 45'h88);
        total++;
        if (buf_wr_addr !== 4'd3 || desc_valid !== 1'b1 || desc_start !== 4'd3 || desc_len !== 5'd1)
            $display("FAIL err_reuse_start: got addr=%0d v=%b start=%0d len=%0d want 3 1 3 1",
                     buf_wr_addr, desc_valid, desc_start, desc_len);
        else pass_cnt++;
        pop_desc();
    endtask

    task automatic test_overflow();
        int wcnt;
        logic exp_ovf;
        apply_reset();
        wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            send_word(32'hD0 + 32'(i), i == 0, i == 19, 1'b0, 45'h99);
            if (buf_wr_en === 1'b1) wcnt++;
            if (i >= 16) begin
                exp_ovf = (i != 19);
                total++;
                if (rx_w_overflow !== exp_ovf)
                    $display("FAIL overflow_flag_w%0d: got %b want %b", i, rx_w_overflow, exp_ovf);
                else pass_cnt++;
            end
        end
        total++;
        if (wcnt != 16)
            $display("FAIL overflow_write_count: got %0d want 16", wcnt);
        else pass_cnt++;
        total++;
        if (desc_valid !== 1'b0)
            $display("FAIL overflow_no_desc: got valid=%b want 0", desc_valid);
        else pass_cnt++;
        send_word(32'hDF, 1'b1, 1'b1, 1'b0, 45'h1);
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd0 || desc_len !== 5'd1)
            $display("FAIL overflow_recover: got v=%b start=%0d len=%0d want 1 0 1",
                     desc_valid, desc_start, desc_len);
        else pass_cnt++;
        pop_desc();
    endtask

    task automatic test_desc_full();
        apply_reset();
        send_word(32'hE0, 1'b1, 1'b1, 1'b0, 45'h10);
        send_word(32'hE1, 1'b1, 1'b1, 1'b0, 45'h11);
        total++;
        if (rx_w_overflow !== 1'b0)
            $display("FAIL descfull_no_early_ovf: got %b want 0", rx_w_overflow);
        else pass_cnt++;
        send_word(32'hE2, 1'b1, 1'b1, 1'b0, 45'h12);
        total++;
        if (rx_w_overflow !== 1'b1 || buf_wr_addr !== 4'd2)
            $display("FAIL descfull_pulse: got ovf=%b addr=%0d want 1 2", rx_w_overflow, buf_wr_addr);
        else pass_cnt++;
        @(posedge rx_clock); #1;
        total++;
        if (rx_w_overflow !== 1'b0)
            $display("FAIL descfull_pulse_end: got %b want 0", rx_w_overflow);
        else pass_cnt++;
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd0 || desc_status !== 45'h10)
            $display("FAIL descfull_head0: got v=%b start=%0d st=%h want 1 0 10",
                     desc_valid, desc_start, desc_status);
        else pass_cnt++;
        pop_desc();
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd1 || desc_status !== 45'h11)
            $display("FAIL descfull_head1: got v=%b start=%0d st=%h want 1 1 11",
                     desc_valid, desc_start, desc_status);
        else pass_cnt++;
        pop_desc();
        total++;
        if (desc_valid !== 1'b0)
            $display("FAIL descfull_empty: got valid=%b want 0", desc_valid);
        else pass_cnt++;
        send_word(32'hE3, 1'b1, 1'b1, 1'b0, 45'h13);
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd2 || desc_len !== 5'd1)
            $display("FAIL descfull_reuse: got v=%b start=%0d len=%0d want 1 2 1",
                     desc_valid, desc_start, desc_len);
        else pass_cnt++;
        pop_desc();
    endtask

    task automatic test_flush();
        apply_reset();
        send_word(32'hF0, 1'b1, 1'b0, 1'b0, 45'h0);
        send_word(32'hF1, 1'b0, 1'b1, 1'b0, 45'h20);
        pop_desc();
        for (int i = 0; i < 5; i++)
            send_word(32'h100 + 32'(i), i == 0, 1'b0, 1'b0, 45'h0);
        rx_w_flush = 1; rx_w_wr = 1; rx_w_sop = 1; rx_w_eop = 1; rx_w_data = 32'hEE;
        @(posedge rx_clock); #1;
        rx_w_flush = 0; rx_w_wr = 0; rx_w_sop = 0; rx_w_eop = 0;
        total++;
        if (buf_wr_en !== 1'b0 || rx_w_overflow !== 1'b0 || desc_valid !== 1'b0)
            $display("FAIL flush_cycle: got en=%b ovf=%b valid=%b want 0 0 0",
                     buf_wr_en, rx_w_overflow, desc_valid);
        else pass_cnt++;
        send_word(32'h200, 1'b1, 1'b0, 1'b0, 45'h0);
        total++;
        if (buf_wr_addr !== 4'd2)
            $display("FAIL flush_rollback_addr: got %0d want 2", buf_wr_addr);
        else pass_cnt++;
        send_word(32'h201, 1'b0, 1'b0, 1'b0, 45'h0);
        send_word(32'h202, 1'b0, 1'b1, 1'b0, 45'h21);
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd2 || desc_len !== 5'd3 || desc_status !== 45'h21)
            $display("FAIL flush_next_desc: got v=%b start=%0d len=%0d st=%h want 1 2 3 21",
                     desc_valid, desc_start, desc_len, desc_status);
        else pass_cnt++;
        pop_desc();
    endtask

    // Continues from test_flush: committed pointer is 5.
    task automatic test_back_to_back();
        send_word(32'h300, 1'b1, 1'b0, 1'b0, 45'h0);
        send_word(32'h301, 1'b0, 1'b0, 1'b0, 45'h0);
        send_word(32'h302, 1'b1, 1'b1, 1'b0, 45'h31);
        total++;
        if (buf_wr_addr !== 4'd5 || buf_wr_data !== 32'h302)
            $display("FAIL restart_addr: got addr=%0d data=%h want 5 302", buf_wr_addr, buf_wr_data);
        else pass_cnt++;
        total++;
        if (desc_valid !== 1'b1 || desc_start !== 4'd5 || desc_len !== 5'd1 || desc_status !== 45'h31)
            $display("FAIL restart_desc: got v=%b start=%0d len=%0d st=%h want 1 5 1 31",
                     desc_valid, desc_start, desc_len, desc_status);
        else pass_cnt++;
        pop_desc();
    endtask

    initial begin
        test_reset();
        test_four_word();
        test_single_word();
        test_err_frame();
        test_overflow();
        test_desc_full();
        test_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
